// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and constants for the SHA-256 message path
package sha256_pkg;
  typedef enum logic [1:0] {S_DATA, S_ZERO, S_LEN} pad_state_t;
  typedef logic [31:0] word_t;
  localparam int BLOCK_BYTES = 64;
  localparam int POS_W = $clog2(BLOCK_BYTES);
  localparam logic [POS_W-1:0] LEN_POS = POS_W'(56);
  localparam logic [7:0] PAD_BYTE = 8'h80;
endpackage

// File: rtl/sha256_msg_padder_if.sv
// sha256_msg_padder_if: byte-in / word-out stream bundle of the padder
interface sha256_msg_padder_if;
  import sha256_pkg::*;
  logic in_valid, in_last, in_nodata, in_ready;
  logic [7:0] in_data;
  logic out_valid, out_ready, out_first, out_last, out_final, busy;
  word_t out_data;
  modport master (
    output in_valid, in_data, in_last, in_nodata, out_ready,
    input in_ready, out_valid, out_data, out_first, out_last, out_final, busy
  );
  modport slave (
    input in_valid, in_data, in_last, in_nodata, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last, out_final, busy
  );
endinterface

// File: rtl/sha256_word_packer.sv
// sha256_word_packer: shifts bytes into big-endian words and holds them under valid/ready
module sha256_word_packer
  import sha256_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_en,
  input  logic [7:0] din,
  input  logic       word_end,
  input  logic       first,
  input  logic       last,
  input  logic       fin,
  input  logic       out_ready,
  output logic       out_valid,
  output word_t      out_data,
  output logic       out_first,
  output logic       out_last,
  output logic       out_final
);
  logic [23:0] acc;
  // shift bytes in; the fourth byte completes a word into the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_first <= 1'b0;
      out_last <= 1'b0;
      out_final <= 1'b0;
    end else begin
      if (byte_en) acc <= {acc[15:0], din};
      if (byte_en && word_end) begin
        out_valid <= 1'b1;
        out_data <= {acc, din};
        out_first <= first;
        out_last <= last;
        out_final <= fin;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: FIPS 180-4 padding of a byte stream into 512-bit blocks of words
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input logic clk,
  input logic rst,
  sha256_msg_padder_if.slave bus
);
  pad_state_t state, state_n;
  logic [POS_W-1:0] pos;
  logic [LEN_W-1:0] count, count_n;
  logic [63:0] len_bits;
  logic pad_pending, busy_q, adv, acc_beat, done, byte_en;
  logic [7:0] byte_val;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (state == S_DATA) && !pad_pending && adv;
  assign acc_beat = bus.in_valid && bus.in_ready;
  assign done = bus.out_valid && bus.out_ready && bus.out_final;
  assign count_n = count + LEN_W'(!bus.in_nodata);
  assign bus.busy = busy_q;
  // pick the byte for this cycle (message, 0x80, fill or length) and the next state
  always_comb begin
    state_n = state;
    byte_en = 1'b0;
    byte_val = '0;
    if (state == S_DATA) begin
      if (pad_pending && adv) begin
        byte_en = 1'b1;
        byte_val = PAD_BYTE;
        state_n = (pos + 1'b1 == LEN_POS) ? S_LEN : S_ZERO;
      end else if (acc_beat && !bus.in_nodata) begin
        byte_en = 1'b1;
        byte_val = bus.in_data;
      end
    end else if (state == S_ZERO) begin
      byte_en = adv;
      state_n = (adv && pos + 1'b1 == LEN_POS) ? S_LEN : S_ZERO;
    end else begin
      byte_en = adv && pos >= LEN_POS;
      byte_val = 8'(len_bits >> {~pos[2:0], 3'b000});
      state_n = done ? S_DATA : S_LEN;
    end
  end
  // state, block position, byte count and latched bit length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_DATA;
      pos <= '0;
      count <= '0;
      len_bits <= '0;
      pad_pending <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state <= state_n;
      pad_pending <= (acc_beat && bus.in_last) ? 1'b1 : (pad_pending && !adv);
      if (done) begin
        pos <= '0;
        count <= '0;
        len_bits <= '0;
        busy_q <= 1'b0;
      end else begin
        if (byte_en) pos <= pos + 1'b1;
        if (acc_beat) count <= count_n;
        if (acc_beat) busy_q <= 1'b1;
        if (acc_beat && bus.in_last) len_bits <= 64'({count_n, 3'b000});
      end
    end
  end
  sha256_word_packer u_packer (
    .clk(clk),
    .rst(rst),
    .byte_en(byte_en),
    .din(byte_val),
    .word_end(pos[1:0] == 2'd3),
    .first(pos == POS_W'(3)),
    .last(&pos),
    .fin((state == S_LEN) && (&pos)),
    .out_ready(bus.out_ready),
    .out_valid(bus.out_valid),
    .out_data(bus.out_data),
    .out_first(bus.out_first),
    .out_last(bus.out_last),
    .out_final(bus.out_final)
  );
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: random and directed messages checked against a padding model
module tb_sha256_msg_padder;
  import sha256_pkg::*;
  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [31:0] d; logic f; logic l; logic z;} ew_t;
  logic clk = 0;
  logic rst = 1;
  sha256_msg_padder_if bus();
  sha256_msg_padder #(.LEN_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  ew_t exp_q[$];
  int hold_cnt = 0;
  bit bp_en = 0;
  bit held = 0;
  bit done_prev = 0;
  ew_t held_v, cur_v, e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // reference: pad the whole message as bytes, then cut into 32-bit words
  function automatic void model(input bq_t m, output ew_t w[$]);
    bq_t p;
    logic [63:0] bits;
    int n;
    p = m;
    bits = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
    n = p.size() / 4;
    w = {};
    for (int i = 0; i < n; i++) begin
      ew_t x;
      x.d = {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
      x.f = (i % 16 == 0);
      x.l = (i % 16 == 15);
      x.z = x.l && (i == n - 1);
      w.push_back(x);
    end
  endfunction

  function automatic bq_t fill(input int n, input logic [7:0] v, input bit rnd);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(rnd ? 8'($urandom) : v);
    return q;
  endfunction

  always begin
    @(posedge clk);
    #1;
    bus.out_ready = (hold_cnt > 0) ? 1'b0 : (bp_en ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (hold_cnt > 0) hold_cnt--;
  end

  always @(negedge clk) begin
    if (rst) begin
      held = 0;
      done_prev = 0;
    end else begin
      cur_v = {bus.out_data, bus.out_first, bus.out_last, bus.out_final};
      if (held) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_word", cur_v, held_v);
      end
      if (done_prev) begin
        chk("busy_after_final", bus.busy, 0);
        chk("in_ready_after_final", bus.in_ready, 1);
      end
      held = 0;
      done_prev = 0;
      if (bus.out_valid && !bus.out_ready) begin
        held = 1;
        held_v = cur_v;
        chk("stall_in_ready", bus.in_ready, 0);
      end
      if (bus.out_valid) chk("busy_while_valid", bus.busy, 1);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %08h expected none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("word{data,first,last,final}", cur_v, e);
          done_prev = e.z;
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l, input logic n);
    int t;
    t = 0;
    bus.in_valid = 1;
    bus.in_data = d;
    bus.in_last = l;
    bus.in_nodata = n;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (++t > 3000) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: in_ready stuck 0, expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    bus.in_last = 0;
    bus.in_nodata = 0;
  endtask

  task automatic send_msg(input bq_t m, input bit marker, input bit gaps);
    ew_t w[$];
    model(m, w);
    foreach (w[i]) exp_q.push_back(w[i]);
    if (m.size() == 0) marker = 1;
    foreach (m[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_beat(m[i], !marker && (i == m.size() - 1), 0);
    end
    if (marker) send_beat(8'($urandom), 1, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 6000) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ew_t w[$];
    bq_t abc, m;
    int t;
    abc = '{8'h61, 8'h62, 8'h63};
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.in_last = 0;
    bus.in_nodata = 0;
    bus.out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("reset_out_data", bus.out_data, 0);
    chk("reset_flags", {bus.out_first, bus.out_last, bus.out_final}, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    model(abc, w);
    chk("model_abc_size", w.size(), 16);
    chk("model_abc_w0", w[0], {32'h61626380, 3'b100});
    chk("model_abc_w15", w[15], {32'h00000018, 3'b011});
    model(fill(0, 0, 0), w);
    chk("model_empty_w0", w[0].d, 32'h80000000);
    chk("model_empty_w15", w[15], {32'h0, 3'b011});
    model(fill(55, 8'h41, 0), w);
    chk("model_55_w13", w[13].d, 32'h41414180);
    chk("model_55_w15", w[15].d, 32'h000001B8);
    model(fill(56, 8'h41, 0), w);
    chk("model_56_size", w.size(), 32);
    chk("model_56_w14", w[14].d, 32'h80000000);
    chk("model_56_w15", w[15], {32'h0, 3'b010});
    chk("model_56_w31", w[31], {32'h000001C0, 3'b011});

    send_msg(abc, 0, 0);
    drain();
    send_msg(fill(0, 0, 0), 1, 0);
    drain();
    send_msg(fill(55, 8'h41, 0), 0, 0);
    send_msg(fill(56, 8'h41, 0), 0, 0);
    drain();

    fork
      send_msg(abc, 0, 0);
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.out_valid && t < 100);
        chk("bp_saw_word", bus.out_valid, 1);
        hold_cnt = 7;
      end
    join
    drain();

    m = fill(30, 0, 1);
    model(m, w);
    foreach (w[i]) exp_q.push_back(w[i]);
    for (int i = 0; i < 10; i++) send_beat(m[i], 0, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    send_msg(abc, 0, 0);
    drain();

    send_msg(fill(20, 0, 1), 0, 0);
    send_msg(fill(61, 0, 1), 1, 0);
    drain();

    bp_en = 1;
    for (int k = 0; k < 20; k++) send_msg(fill($urandom_range(0, 140), 0, 1), 1'($urandom), 1);
    drain();
    bp_en = 0;
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Byte-stream front end of the UART SHA-256 path. It sits between the UART receive/command logic and the SHA-256 compression core. It accepts raw message bytes and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. It delivers the padded message to the core as 16 big-endian 32-bit words per 512-bit block, with valid/ready flow control on both sides.

## Interface
- LEN_W, default 32: width of the internal message byte counter. The bit length is {count, 3'b000}, zero-extended to 64 bits. Counts wrap modulo 2^LEN_W.
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset (the one clock, async active-high reset is fixed for this block).
- in_valid  in  1  byte offer from the upstream side.
- in_data  in  8  message byte.
- in_last  in  1  this beat ends the message.
- in_nodata  in  1  only meaningful with in_last. The beat carries no byte (empty message, or end marker after the final byte).
- in_ready  out  1  the beat is accepted when in_valid && in_ready.
- out_valid  out  1  word available.
- out_data  out  32  padded message word, big-endian (first byte in [31:24]).
- out_ready  in  1  the core accepts the word.
- out_first  out  1  word 0 of a block.
- out_last  out  1  word 15 of a block.
- out_final  out  1  asserted with out_last on the last block of the message.
- busy  out  1  high from the first accepted byte until the final word handshake.

## Operation
- States: S_DATA, S_ZERO, S_LEN.
  - S_DATA absorbs message bytes.
  - S_ZERO emits 0x00 fill.
  - S_LEN emits the 8 length bytes, MSB first.
- A 4-byte assembler and a 6-bit block byte position `pos` (0..63) advance by one byte per cycle, for message and pad bytes alike.
- When the 4th byte enters the assembler, the word moves into the output register. out_first is set when pos==3, and out_last when pos==63.
- S_DATA, on an accepted beat:
  - If in_nodata=0: append in_data, increment the byte count.
  - If in_last=1: latch len_bits = {count_after_this_beat, 3'b0}. In the following cycle append 0x80.
  - After 0x80, go to S_ZERO if the new pos != 56, otherwise go to S_LEN.
- S_ZERO: append 0x00 each cycle until pos==56, then go to S_LEN. If 0x80 landed at pos 56..63, zero fill runs through 63, wraps to 0, and continues to 56 in the next block.
- S_LEN: append len_bits[63:56] down to [7:0] at pos 56..63. The word with pos==63 carries out_final=1.
- On the handshake of the final word, return to S_DATA and clear the count, pos and len_bits.
- in_ready = (state==S_DATA) && !pad_pending && (!out_valid || out_ready).
- Internal pad and length bytes are generated under the same stall condition as in_ready.
- in_last with in_nodata=1 on a fresh message gives an empty message: one block with 0x80000000, 14 zero words, and 0x00000000 as the length.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_first/out_last/out_final=0, busy=0.
  - state=S_DATA, pos=0, count=0.
  - in_ready reads 1 after release.
- Throughput is 1 byte/cycle, so 1 word per 4 cycles, while out_ready stays high.
- Latency: out_valid rises the cycle after the 4th byte of a word is accepted or generated.
- out_data, out_first, out_last and out_final stay stable while out_valid && !out_ready.
- With out_ready low and a full word held, no byte is accepted or generated and the assembler holds.
- Padding for a message of L bytes emits 64*ceil((L+9)/64) - L bytes after the last data byte.
- Reset mid-message or mid-padding aborts immediately. Nothing partial is emitted after release.
- in_last with in_nodata=0 and then a separate end marker is not legal. Exactly one in_last beat per message.

## Structure
- sha256_pkg (shared with the core and UART front end) holds:
  - the state enum;
  - BLOCK_BYTES=64, LEN_POS=56, PAD_BYTE=8'h80;
  - the word-type typedef.
- Optional sub-module sha256_word_packer: the byte-to-word assembler and output register with valid/ready. The FSM and counters stay in sha256_msg_padder.

## Test plan
- "abc" (0x61,0x62,0x63, last on 0x63) -> 16 words: 0x61626380, 14×0x00000000, 0x00000018. out_first on word 0; out_last and out_final on word 15.
- Empty message (in_last+in_nodata) -> 0x80000000, 14×0, 0x00000000; busy returns to 0 after the handshake.
- 55 bytes of 0x41 -> one block; word 13 = 0x41414180; words 14,15 = 0x00000000, 0x000001B8.
- 56 bytes of 0x41 -> two blocks. Block 1 word 14 = 0x80000000 and word 15 = 0, out_final=0. Block 2 = 14 zero words, then 0, 0x000001C0 with out_final=1.
- Backpressure: hold out_ready=0 for 7 cycles mid-"abc" padding -> in_ready=0 and out_data held unchanged. The word sequence is identical to the first scenario.
- Assert rst after 10 bytes of a message, then send "abc" -> output exactly as in the first scenario. Also send two back-to-back messages with no idle gap: both produce correct blocks.
